ssd_scan_driver: RTL

- Time-multiplexed 8-digit seven-segment scanner for the Nexys A7 display. It sits downstream of the counter/decoder path and takes over the physical SSD pins.
- Holds a 32-bit hex value (8 nibbles) plus 8 decimal points and cycles one anode at a time, so all 8 digits appear lit.
- New values are staged and committed only at a frame boundary, so the display never tears mid-scan.

---
 rtl/ssd_scan_driver.sv | 116 +++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 8-digit seven-segment scanner with frame-synchronous commit of
// staged display data, per-digit masking and optional leading-zero suppression.
module ssd_scan_driver #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        ssd_scan_clk,
  input  logic        ssd_scan_rst,
  input  logic [31:0] ssd_scan_inp,
  input  logic [7:0]  ssd_scan_idp,
  input  logic        ssd_scan_load,
  input  logic [7:0]  ssd_scan_mask,
  input  logic        ssd_scan_lzs,
  output logic [6:0]  ssd_scan_cc,
  output logic        ssd_scan_odp,
  output logic [7:0]  ssd_scan_an,
  output logic        ssd_scan_ack
);

  localparam logic [REFRESH_BITS-1:0] CNT_ONE = REFRESH_BITS'(1);

  logic [REFRESH_BITS-1:0] cnt;
  logic [2:0]              idx;
  logic [31:0]             staging_val;
  logic [7:0]              staging_dp;
  logic [31:0]             shadow_val;
  logic [7:0]              shadow_dp;
  logic                    pending;

  logic       tick;
  logic       frame_end;
  logic [3:0] nib;
  logic       upper_zero;
  logic       visible;
  logic [6:0] seg;

  assign tick      = &cnt;
  assign frame_end = tick && (idx == 3'd7);

  // Suppression looks at the current digit and every digit to its left.
  always_comb begin
    nib        = shadow_val[{idx, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(idx) && shadow_val[i*4 +: 4] != 4'h0) upper_zero = 1'b0;
    end
    visible = ssd_scan_mask[idx] && !(ssd_scan_lzs && (idx != 3'd0) && upper_zero);
  end

  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'h7F;
    endcase
  end

  always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst) begin
    if (!ssd_scan_rst) begin
      cnt          <= '0;
      idx          <= 3'd0;
      staging_val  <= 32'h0;
      staging_dp   <= 8'h0;
      shadow_val   <= 32'h0;
      shadow_dp    <= 8'h0;
      pending      <= 1'b0;
      ssd_scan_an  <= 8'hFF;
      ssd_scan_cc  <= 7'h7F;
      ssd_scan_odp <= 1'b1;
      ssd_scan_ack <= 1'b0;
    end else begin
      cnt <= cnt + CNT_ONE;
      if (tick) idx <= idx + 3'd1;

      if (ssd_scan_load) begin
        staging_val <= ssd_scan_inp;
        staging_dp  <= ssd_scan_idp;
      end

      // A load coinciding with the commit stays pending for the next frame.
      if (frame_end && pending) begin
        shadow_val   <= staging_val;
        shadow_dp    <= staging_dp;
        ssd_scan_ack <= 1'b1;
      end else begin
        ssd_scan_ack <= 1'b0;
      end
      pending <= ssd_scan_load || (pending && !frame_end);

      if (visible) begin
        ssd_scan_an  <= ~(8'b1 << idx);
        ssd_scan_cc  <= seg;
        ssd_scan_odp <= ~shadow_dp[idx];
      end else begin
        ssd_scan_an  <= 8'hFF;
        ssd_scan_cc  <= 7'h7F;
        ssd_scan_odp <= 1'b1;
      end
    end
  end

endmodule
